tone_arbiter: RTL and testbench
===============================

Name: tone_arbiter

Overview:
Shares the single square-wave tone generator (`Music`, driven by a 15-bit half-period `notetime`) among several note sources, e.g. song player, key-click beeper and alarm.
- Fixed-priority arbitration with a minimum-hold window, so a short high-priority burst cannot chop a note into clicks.
- A forced silence gap on every change of owner.
- Sits between the note sources and the `Music` instance in the top level.

Parameters:
N_REQ, 3, number of requesters; index 0 is highest priority.
NOTE_W, 15, width of a note half-period word; matches the `Music` notetime.
MIN_HOLD, 120000, clk12MHz cycles an owner keeps the generator before a higher-priority requester may preempt it (10 ms).
GAP_CYCLES, 12000, clk12MHz cycles of forced silence on every ownership change (1 ms); must be >= 1.

Ports:
clk12MHz  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request level; held high while the requester wants the generator
req_note  input  N_REQ*NOTE_W  packed note words; requester i at [i*NOTE_W +: NOTE_W]; 0 = rest
grant  output  N_REQ  one-hot current owner; all-zero when idle or in a gap
notetime  output  NOTE_W  registered note word to `Music`; 0 = silent
busy  output  1  high in PLAY and GAP

Behaviour:
- Clock and reset: one clock (clk12MHz); reset is synchronous and active-high. All outputs are registered.
- Reset values: grant=0, notetime=0, busy=0, state=IDLE, hold and gap counters=0. Reset mid-PLAY or mid-GAP silences the output on the next edge.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If req is all zero, stay in IDLE with outputs at 0.
  - Otherwise, at the next edge: owner = lowest set index of req, grant=onehot(owner), notetime=req_note[owner], hold=0, busy=1, go to PLAY.
  - Latency: req rises at edge t, grant and notetime are valid after edge t+1.
- PLAY:
  - Each cycle: notetime <= req_note[owner], so note changes follow with 1-cycle latency. A note word of 0 (rest) keeps ownership.
  - hold increments and saturates at MIN_HOLD.
  - Leave to GAP when either:
    - (a) req[owner]=0 (release, honoured immediately regardless of hold), or
    - (b) some req[j]=1 with j<owner and hold==MIN_HOLD (preemption).
  - On entering GAP: grant=0, notetime=0, gap=0.
  - A lower-priority request never preempts; it waits.
  - Release and higher-priority assertion in the same cycle is treated as release (no hold check).
- GAP:
  - notetime=0, grant=0, busy=1; gap increments each cycle.
  - When gap==GAP_CYCLES-1, rearbitrate at that edge, exactly as from IDLE:
    - any req set -> PLAY with the new owner (the previous owner is eligible again);
    - none set -> IDLE with busy=0.
  - Silence therefore lasts exactly GAP_CYCLES cycles of notetime=0.
  - Requests that arrive or drop during GAP are only sampled at rearbitration.
- Width rules:
  - hold and gap counters are $clog2(max+1) bits.
  - The note mux indexes the packed bus with +: slicing.
  - No arithmetic is applied to note words.
- Invariant: grant is one-hot or zero; notetime!=0 implies grant!=0.

Decomposition:
- Shared package `music_pkg`: NOTE_W, state encodings (IDLE/PLAY/GAP localparams), the rest-note constant 0.
- One sub-module, `prio_onehot`: combinational N_REQ-bit fixed-priority encoder (lowest index wins), returning a one-hot vector plus a valid flag. It is used by both IDLE and GAP arbitration.

Test Plan (bench uses N_REQ=3, MIN_HOLD=8, GAP_CYCLES=4):
1. Reset, then req=3'b100 with note2=15'd11364 at edge 10 -> grant=3'b100, notetime=11364 from edge 11; drop req at edge 30 -> notetime=0 edges 31-34, then IDLE with busy=0.
2. Owner 2 playing; req[0] rises at hold=3 -> no preemption until hold=8; then 4 silent cycles, then grant=3'b001, notetime=note0.
3. Owner 0 playing; req[1] asserted -> grant stays 3'b001 indefinitely. Release req[0] -> gap of 4, then grant=3'b010.
4. Owner 1 changes note 9555->7584 mid-play -> notetime updates exactly 1 cycle later with no gap. Note 0 keeps grant=3'b010.
5. Reset pulse mid-GAP and mid-PLAY -> next edge all outputs 0, state IDLE. Held req=3'b001 is then regranted one cycle after reset deasserts.
6. Same-edge release of owner 2 and assertion of req[0] at hold=2 -> GAP entered (release path), then grant=3'b001 after 4 cycles.

Source files
------------

// File: rtl/music_pkg.sv
// Shared constants for the tone generator path: note word width, arbiter state
// encodings and the rest (silent) note.
package music_pkg;

   localparam int NOTE_W = 15;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t PLAY = 2'd1;
   localparam state_t GAP  = 2'd2;

   localparam logic [NOTE_W-1:0] REST_NOTE = '0;

endpackage

// File: rtl/tone_arbiter_if.sv
// Bundle between the note sources and the arbiter. The sources form the master
// side; the arbiter is the slave and returns grant, note and busy.
interface tone_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int NOTE_W = 15
) ();

   logic [N_REQ-1:0]        req;
   logic [N_REQ*NOTE_W-1:0] req_note;
   logic [N_REQ-1:0]        grant;
   logic [NOTE_W-1:0]       notetime;
   logic                    busy;

   modport master (
      output req,
      output req_note,
      input  grant,
      input  notetime,
      input  busy
   );

   modport slave (
      input  req,
      input  req_note,
      output grant,
      output notetime,
      output busy
   );

endinterface

// File: rtl/tone_arbiter_prio_onehot.sv
// Fixed-priority encoder: the lowest set index of req wins. Returns the winner
// as a one-hot vector plus a flag that any request is present.
module prio_onehot #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] onehot,
   output logic         valid
);

   always_comb begin
      onehot = '0;
      valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !valid) begin
            onehot[i] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tone_arbiter.sv
// Shares the single Music tone generator among several note sources with
// fixed priority, a minimum-hold window and a forced silence gap on hand-over.
//
//  state | meaning
//  IDLE  | no owner, generator silent, busy low
//  PLAY  | one owner drives the generator; hold counts up to MIN_HOLD
//  GAP   | forced silence after an owner change; gap counts to GAP_CYCLES-1
module tone_arbiter #(
   parameter int N_REQ      = 3,
   parameter int NOTE_W     = 15,
   parameter int MIN_HOLD   = 120000,
   parameter int GAP_CYCLES = 12000
) (
   input logic           clk12MHz,
   input logic           reset,
   tone_arbiter_if.slave bus
);

   import music_pkg::*;

   localparam int HOLD_W = $clog2(MIN_HOLD + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [NOTE_W-1:0] SILENT   = NOTE_W'(REST_NOTE);

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [NOTE_W-1:0]   notetime_q, notetime_d;
   logic                busy_q, busy_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [GAP_W-1:0]    gap_q, gap_d;

   logic [N_REQ-1:0]    win_oh;
   logic                win_vld;
   logic [NOTE_W-1:0]   win_note;
   logic [NOTE_W-1:0]   own_note;
   logic                owner_req;
   logic                higher_req;
   logic                hold_done;

   prio_onehot #(.N(N_REQ)) u_prio (
      .req    (bus.req),
      .onehot (win_oh),
      .valid  (win_vld)
   );

   // One-hot selects make the note muxes a plain AND-OR over the packed bus.
   always_comb begin
      win_note = SILENT;
      own_note = SILENT;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_oh[i])  win_note = win_note | bus.req_note[i*NOTE_W +: NOTE_W];
         if (grant_q[i]) own_note = own_note | bus.req_note[i*NOTE_W +: NOTE_W];
      end
   end

   // grant_q - 1 masks exactly the indices above the owner in priority.
   assign owner_req  = |(bus.req & grant_q);
   assign higher_req = |(bus.req & (grant_q - N_REQ'(1)));
   assign hold_done  = (hold_q == HOLD_MAX);

   always_ff @(posedge clk12MHz) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         notetime_q <= SILENT;
         busy_q     <= 1'b0;
         hold_q     <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         notetime_q <= notetime_d;
         busy_q     <= busy_d;
         hold_q     <= hold_d;
         gap_q      <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (win_vld) state_d = PLAY;
         end
         PLAY: begin
            if (!owner_req || (higher_req && hold_done)) state_d = GAP;
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = win_vld ? PLAY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d    = grant_q;
      notetime_d = notetime_q;
      busy_d     = busy_q;
      hold_d     = hold_q;
      gap_d      = gap_q;
      if (state_q == PLAY) begin
         if (state_d == GAP) begin
            grant_d    = '0;
            notetime_d = SILENT;
            busy_d     = 1'b1;
            gap_d      = '0;
         end else begin
            notetime_d = own_note;
            hold_d     = hold_done ? hold_q : hold_q + HOLD_W'(1);
         end
      end else begin
         // IDLE and the last GAP cycle arbitrate identically.
         if (state_d == PLAY) begin
            grant_d    = win_oh;
            notetime_d = win_note;
            busy_d     = 1'b1;
            hold_d     = '0;
         end else if (state_d == GAP) begin
            grant_d    = '0;
            notetime_d = SILENT;
            busy_d     = 1'b1;
            gap_d      = gap_q + GAP_W'(1);
         end else begin
            grant_d    = '0;
            notetime_d = SILENT;
            busy_d     = 1'b0;
         end
      end
   end

   assign bus.grant    = grant_q;
   assign bus.notetime = notetime_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter: each step drives one cycle of inputs and
// queues the output expected after the next edge; a monitor pops and compares.
module tb_tone_arbiter;

   localparam int N_REQ      = 3;
   localparam int NOTE_W     = 15;
   localparam int MIN_HOLD   = 8;
   localparam int GAP_CYCLES = 4;

   localparam logic [14:0] NOTE0 = 15'd5000;
   localparam logic [14:0] NOTE1 = 15'd9555;
   localparam logic [14:0] NOTE2 = 15'd11364;

   logic clk12MHz = 1'b0;
   logic reset    = 1'b1;

   always #5 clk12MHz = ~clk12MHz;

   tone_arbiter_if #(.N_REQ(N_REQ), .NOTE_W(NOTE_W)) bus ();

   tone_arbiter #(
      .N_REQ      (N_REQ),
      .NOTE_W     (NOTE_W),
      .MIN_HOLD   (MIN_HOLD),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk12MHz (clk12MHz),
      .reset    (reset),
      .bus      (bus)
   );

   logic [14:0] note0, note1, note2;
   assign bus.req_note = {note2, note1, note0};

   typedef struct {
      string       tag;
      logic [2:0]  grant;
      logic [14:0] note;
      logic        busy;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic step(input logic rst, input logic [2:0] r, input logic [2:0] eg,
                       input logic [14:0] en, input logic eb, input string tag);
      exp_t e;
      reset   = rst;
      bus.req = r;
      e.tag   = tag;
      e.grant = eg;
      e.note  = en;
      e.busy  = eb;
      sb_q.push_back(e);
      @(negedge clk12MHz);
   endtask

   task automatic stepn(input int n, input logic rst, input logic [2:0] r, input logic [2:0] eg,
                        input logic [14:0] en, input logic eb, input string tag);
      for (int k = 0; k < n; k++) step(rst, r, eg, en, eb, tag);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk12MHz);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (bus.grant !== e.grant || bus.notetime !== e.note || bus.busy !== e.busy) begin
               miscompares++;
               $display("FAIL %s (vector %0d): got grant=%b notetime=%0d busy=%b, want grant=%b notetime=%0d busy=%b",
                        e.tag, vectors, bus.grant, bus.notetime, bus.busy, e.grant, e.note, e.busy);
            end
         end
      end
   end

   initial begin : stimulus
      bus.req = 3'b000;
      note0   = NOTE0;
      note1   = NOTE1;
      note2   = NOTE2;
      @(negedge clk12MHz);

      stepn(2, 1'b1, 3'b000, 3'b000, 15'd0, 1'b0, "reset");
      stepn(3, 1'b0, 3'b000, 3'b000, 15'd0, 1'b0, "idle");

      // single owner, release, full gap then back to idle
      step (   1'b0, 3'b100, 3'b100, NOTE2, 1'b1, "t1_grant");
      stepn(5, 1'b0, 3'b100, 3'b100, NOTE2, 1'b1, "t1_play");
      stepn(4, 1'b0, 3'b000, 3'b000, 15'd0, 1'b1, "t1_gap");
      step (   1'b0, 3'b000, 3'b000, 15'd0, 1'b0, "t1_idle");

      // higher priority waits for hold to reach MIN_HOLD
      step (   1'b0, 3'b100, 3'b100, NOTE2, 1'b1, "t2_grant");
      stepn(3, 1'b0, 3'b100, 3'b100, NOTE2, 1'b1, "t2_play");
      stepn(5, 1'b0, 3'b101, 3'b100, NOTE2, 1'b1, "t2_hold");
      stepn(4, 1'b0, 3'b101, 3'b000, 15'd0, 1'b1, "t2_gap");
      step (   1'b0, 3'b101, 3'b001, NOTE0, 1'b1, "t2_preempt");

      // lower priority never preempts; release hands over after the gap
      stepn(12, 1'b0, 3'b011, 3'b001, NOTE0, 1'b1, "t3_lowwait");
      stepn(4,  1'b0, 3'b010, 3'b000, 15'd0, 1'b1, "t3_gap");
      step (    1'b0, 3'b010, 3'b010, NOTE1, 1'b1, "t3_grant1");

      // note changes and rests follow one cycle later without a gap
      stepn(2, 1'b0, 3'b010, 3'b010, NOTE1, 1'b1, "t4_play");
      note1 = 15'd7584;
      stepn(2, 1'b0, 3'b010, 3'b010, 15'd7584, 1'b1, "t4_change");
      note1 = 15'd0;
      stepn(2, 1'b0, 3'b010, 3'b010, 15'd0, 1'b1, "t4_rest");
      note1 = NOTE1;
      step (   1'b0, 3'b010, 3'b010, NOTE1, 1'b1, "t4_back");

      // reset mid-GAP and mid-PLAY
      step (1'b0, 3'b000, 3'b000, 15'd0, 1'b1, "t5_gap");
      step (1'b1, 3'b000, 3'b000, 15'd0, 1'b0, "t5_rst_gap");
      step (1'b0, 3'b001, 3'b001, NOTE0, 1'b1, "t5_grant0");
      step (1'b0, 3'b001, 3'b001, NOTE0, 1'b1, "t5_play");
      step (1'b1, 3'b001, 3'b000, 15'd0, 1'b0, "t5_rst_play");
      step (1'b0, 3'b001, 3'b001, NOTE0, 1'b1, "t5_regrant");

      // same-edge release and higher request at hold=2 takes the release path
      stepn(4, 1'b0, 3'b000, 3'b000, 15'd0, 1'b1, "t6_gap0");
      step (   1'b0, 3'b000, 3'b000, 15'd0, 1'b0, "t6_idle");
      step (   1'b0, 3'b100, 3'b100, NOTE2, 1'b1, "t6_grant2");
      stepn(2, 1'b0, 3'b100, 3'b100, NOTE2, 1'b1, "t6_play");
      step (   1'b0, 3'b001, 3'b000, 15'd0, 1'b1, "t6_release");
      stepn(3, 1'b0, 3'b001, 3'b000, 15'd0, 1'b1, "t6_gap");
      step (   1'b0, 3'b001, 3'b001, NOTE0, 1'b1, "t6_grant0");

      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk12MHz);
      if (sb_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
